melody_player: RTL and testbench

//   Sequencer that reads the 7-entry, 2-bit melody ROM and plays it as a square wave.

---
 rtl/melody_player.sv | 121 ++++++++++++
 tb/tb_melody_player.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_player.sv
// Melody sequencer: walks the melody ROM, holds each note for a fixed time,
// and renders the note code as a square wave on tone_out.
module melody_player #(
  parameter int ADDR_W      = 3,
  parameter int NUM_NOTES   = 7,
  parameter int NOTE_CYCLES = 12_500_000,
  parameter int CNT_W       = 24,
  parameter int HALF_P1     = 28_409,
  parameter int HALF_P2     = 25_310,
  parameter int HALF_P3     = 23_889
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [1:0]        rom_q,
  output logic              tone_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0]  NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_NOTES - 1);

  state_t           state;
  logic [1:0]       note_reg;
  logic [CNT_W-1:0] dur_cnt;
  logic [CNT_W-1:0] half_cnt;

  // Terminal half-period count for a note code; code 0 (rest) never toggles.
  function automatic logic [CNT_W-1:0] half_last(input logic [1:0] code);
    case (code)
      2'd1:    return CNT_W'(HALF_P1 - 1);
      2'd2:    return CNT_W'(HALF_P2 - 1);
      2'd3:    return CNT_W'(HALF_P3 - 1);
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      tone_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      note_reg <= '0;
      dur_cnt  <= '0;
      half_cnt <= '0;
    end else begin
      done <= 1'b0;
      // stop overrides everything once playback is under way
      if (stop && (state != S_IDLE)) begin
        state    <= S_IDLE;
        rom_addr <= '0;
        tone_out <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              state    <= S_FETCH;
              rom_addr <= '0;
              busy     <= 1'b1;
            end
          end
          S_FETCH: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            note_reg <= rom_q;
            dur_cnt  <= '0;
            half_cnt <= '0;
            tone_out <= 1'b0;
            state    <= S_PLAY;
          end
          S_PLAY: begin
            if (note_reg != 2'd0) begin
              if (half_cnt == half_last(note_reg)) begin
                tone_out <= ~tone_out;
                half_cnt <= '0;
              end else begin
                half_cnt <= half_cnt + CNT_W'(1);
              end
            end
            if (dur_cnt == NOTE_LAST) begin
              if (rom_addr == ADDR_LAST) begin
                tone_out <= 1'b0;
                done     <= 1'b1;
                state    <= S_DONE;
              end else begin
                rom_addr <= rom_addr + ADDR_W'(1);
                state    <= S_FETCH;
              end
            end else begin
              dur_cnt <= dur_cnt + CNT_W'(1);
            end
          end
          S_DONE: begin
            state    <= S_IDLE;
            rom_addr <= '0;
            busy     <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: registered ROM model plus a timeline reference
// model derived from note period, half-period and run length arithmetic.
module tb_melody_player;

  localparam int ADDR_W      = 3;
  localparam int NUM_NOTES   = 7;
  localparam int NOTE_CYCLES = 16;
  localparam int CNT_W       = 24;
  localparam int HP1         = 2;
  localparam int HP2         = 3;
  localparam int HP3         = 4;
  localparam int NOTE_PERIOD = NOTE_CYCLES + 2;
  localparam int RUN_LEN     = NUM_NOTES * NOTE_PERIOD + 1;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop  = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [1:0]        rom_q;
  logic              tone_out;
  logic              busy;
  logic              done;

  logic [1:0] rom [0:7];
  int n_cmp = 0;
  int n_bad = 0;

  melody_player #(
    .ADDR_W(ADDR_W), .NUM_NOTES(NUM_NOTES), .NOTE_CYCLES(NOTE_CYCLES),
    .CNT_W(CNT_W), .HALF_P1(HP1), .HALF_P2(HP2), .HALF_P3(HP3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .rom_addr(rom_addr), .rom_q(rom_q), .tone_out(tone_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  function automatic int half_of(input logic [1:0] code);
    case (code)
      2'd1:    return HP1;
      2'd2:    return HP2;
      2'd3:    return HP3;
      default: return 0;
    endcase
  endfunction

  task automatic load_default_rom();
    rom[0] = 2'd3; rom[1] = 2'd2; rom[2] = 2'd1; rom[3] = 2'd2;
    rom[4] = 2'd3; rom[5] = 2'd3; rom[6] = 2'd3; rom[7] = 2'd0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({rom_addr, tone_out, busy, done} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_state: got addr=%0d tone=%b busy=%b done=%b, want all 0",
               rom_addr, tone_out, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    // t=7 is PLAY cycle 4 of note 0 (code 3): first high half-period
    n_cmp++;
    if (tone_out !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_preplay: got tone=%b busy=%b, want tone=1 busy=1", tone_out, busy);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({rom_addr, tone_out, busy, done} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_async: got addr=%0d tone=%b busy=%b done=%b, want all 0",
               rom_addr, tone_out, busy, done);
    end
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rom_addr, tone_out, busy, done} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d: got addr=%0d tone=%b busy=%b done=%b, want all 0",
                 i, rom_addr, tone_out, busy, done);
      end
    end
  endtask

  // Full run against the timeline model; poke re-pulses start while busy.
  task automatic test_playback(input string name, input bit poke);
    int idx, ph, h, dones;
    logic [ADDR_W-1:0] e_addr;
    logic e_busy, e_done, e_tone;
    dones = 0;
    repeat ($urandom_range(0, 4)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= RUN_LEN + 3; t++) begin
      idx = 0;
      ph  = -1;
      if (t < RUN_LEN) begin
        idx    = (t - 1) / NOTE_PERIOD;
        ph     = (t - 1) % NOTE_PERIOD;
        e_addr = idx[ADDR_W-1:0];
        e_busy = 1'b1;
        e_done = 1'b0;
      end else if (t == RUN_LEN) begin
        e_addr = ADDR_W'(NUM_NOTES - 1);
        e_busy = 1'b1;
        e_done = 1'b1;
      end else begin
        e_addr = '0;
        e_busy = 1'b0;
        e_done = 1'b0;
      end
      if (done === 1'b1) dones++;
      n_cmp++;
      if (rom_addr !== e_addr || busy !== e_busy || done !== e_done) begin
        n_bad++;
        $display("FAIL %s ctrl t=%0d: got addr=%0d busy=%b done=%b, want addr=%0d busy=%b done=%b",
                 name, t, rom_addr, busy, done, e_addr, e_busy, e_done);
      end
      if (ph >= 2 || t >= RUN_LEN) begin
        e_tone = 1'b0;
        if (ph >= 2) begin
          h = half_of(rom[idx]);
          if (h != 0) e_tone = (((ph - 2) / h) % 2) == 1;
        end
        n_cmp++;
        if (tone_out !== e_tone) begin
          n_bad++;
          $display("FAIL %s tone t=%0d note=%0d: got %b want %b", name, t, idx, tone_out, e_tone);
        end
      end
      start = poke && (t < RUN_LEN) && ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL %s done_count: got %0d pulses want 1", name, dones);
    end
  endtask

  task automatic test_sequence();
    load_default_rom();
    test_playback("sequence", 1'b0);
  endtask

  task automatic test_start_ignored();
    load_default_rom();
    test_playback("start_ignored", 1'b1);
  endtask

  task automatic test_rest_note();
    int k;
    load_default_rom();
    k = $urandom_range(0, NUM_NOTES - 1);
    rom[k] = 2'd0;
    test_playback("rest_note", 1'b0);
  endtask

  task automatic test_random_rom();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NUM_NOTES; i++) rom[i] = 2'($urandom_range(0, 3));
      test_playback("random_rom", 1'b0);
    end
  endtask

  task automatic test_stop();
    int t_stop;
    load_default_rom();
    t_stop = 3 * NOTE_PERIOD + 3 + $urandom_range(0, NOTE_CYCLES - 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (t_stop - 1) @(negedge clk);
    n_cmp++;
    if (rom_addr !== 3'd3 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_pre: got addr=%0d busy=%b want addr=3 busy=1", rom_addr, busy);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_cmp++;
    if ({rom_addr, tone_out, busy, done} !== 6'b0) begin
      n_bad++;
      $display("FAIL stop_next: got addr=%0d tone=%b busy=%b done=%b, want all 0",
               rom_addr, tone_out, busy, done);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rom_addr, tone_out, busy, done} !== 6'b0) begin
        n_bad++;
        $display("FAIL stop_idle cyc=%0d: got addr=%0d tone=%b busy=%b done=%b, want all 0",
                 i, rom_addr, tone_out, busy, done);
      end
    end
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({rom_addr, tone_out, busy, done} !== 6'b0) begin
        n_bad++;
        $display("FAIL start_stop_idle cyc=%0d: got addr=%0d tone=%b busy=%b done=%b, want all 0",
                 i, rom_addr, tone_out, busy, done);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    load_default_rom();
    repeat (2) @(negedge clk);
    test_reset();
    test_sequence();
    test_start_ignored();
    test_rest_note();
    test_random_rom();
    test_stop();
    test_start_stop_idle();
    test_sequence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
